// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular first-word-fall-through instruction queue between
//               instruction fetch and decode. Each entry holds an
//               instruction word and its fetch address plus one.
//
// Ports
//   clk               : single clock, all state updates on the rising edge
//   rst               : synchronous active-high reset
//   if_valid          : fetch side offers a word this cycle
//   if_instr[15:0]    : offered instruction word
//   if_pc[15:0]       : address the offered word was fetched from
//   if_ready          : queue accepts a word this cycle (not full)
//   flow_change_ID_EX : taken branch/jump, flushes the queue
//   stall_IM_ID       : decode stalled, head entry held
//   instr_IM_ID[15:0] : head instruction (NOP_INSTR when empty)
//   pc_IM_ID[15:0]    : head entry's fetch address + 1 (0 when empty)
//   id_valid          : head entry is valid
//   count             : number of valid entries
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [15:0]              if_instr,
    input  logic [15:0]              if_pc,
    output logic                     if_ready,
    input  logic                     flow_change_ID_EX,
    input  logic                     stall_IM_ID,
    output logic [15:0]              instr_IM_ID,
    output logic [15:0]              pc_IM_ID,
    output logic                     id_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // Storage carries no reset; validity is tracked solely by r_count.
    logic [15:0]      r_instr_mem [DEPTH];
    logic [15:0]      r_pc_mem    [DEPTH];

    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_CW-1:0]  r_count;

    logic             w_push;
    logic             w_pop;
    logic [15:0]      w_pc_inc;

    // if_ready looks only at registered occupancy so that the fetch side
    // never sees a combinational path from the decode stall.
    assign if_ready = (r_count != c_FULL);
    assign id_valid = (r_count != '0);
    assign count    = r_count;

    // A flush discards whatever push or pop would otherwise happen.
    assign w_push   = if_valid && if_ready && !flow_change_ID_EX;
    assign w_pop    = id_valid && !stall_IM_ID && !flow_change_ID_EX;

    // 16-bit modulo increment: 16'hFFFF wraps to 16'h0000.
    assign w_pc_inc = if_pc + 16'd1;

    // Head is masked when empty so stale storage is never visible.
    assign instr_IM_ID = id_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
    assign pc_IM_ID    = id_valid ? r_pc_mem[r_rd_ptr]    : 16'h0000;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= if_instr;
            r_pc_mem[r_wr_ptr]    <= w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flow_change_ID_EX) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly c_AW bits wide, so wrap is implicit.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          c_DEPTH = 4;
    localparam logic [15:0] c_NOP   = 16'hF00D;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready;
    logic        flow_change_ID_EX;
    logic        stall_IM_ID;
    logic [15:0] instr_IM_ID;
    logic [15:0] pc_IM_ID;
    logic        id_valid;
    logic [2:0]  count;

    int checks;
    int errors;

    fetch_queue #(
        .DEPTH     (c_DEPTH),
        .NOP_INSTR (c_NOP)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .if_valid          (if_valid),
        .if_instr          (if_instr),
        .if_pc             (if_pc),
        .if_ready          (if_ready),
        .flow_change_ID_EX (flow_change_ID_EX),
        .stall_IM_ID       (stall_IM_ID),
        .instr_IM_ID       (instr_IM_ID),
        .pc_IM_ID          (pc_IM_ID),
        .id_valid          (id_valid),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are examined 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] instr, input logic [15:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic head(input string tag, input logic v, input logic [15:0] ins,
                        input logic [15:0] pc, input logic [2:0] cnt);
        check({tag, ".id_valid"}, 32'(id_valid), 32'(v));
        check({tag, ".instr"},    32'(instr_IM_ID), 32'(ins));
        check({tag, ".pc"},       32'(pc_IM_ID), 32'(pc));
        check({tag, ".count"},    32'(count), 32'(cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if_valid = 1'b0;
        if_instr = 16'h0000;
        if_pc = 16'h0000;
        flow_change_ID_EX = 1'b0;
        stall_IM_ID = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        head("reset", 1'b0, c_NOP, 16'h0000, 3'd0);
        check("reset.if_ready", 32'(if_ready), 32'd1);

        // Single push, one-cycle latency
        offer(16'hA123, 16'h0010);
        tick();
        if_valid = 1'b0;
        head("push1", 1'b1, 16'hA123, 16'h0011, 3'd1);

        // Stall and fill; head must hold
        stall_IM_ID = 1'b1;
        offer(16'hB001, 16'h0020);
        tick();
        head("fill2", 1'b1, 16'hA123, 16'h0011, 3'd2);
        offer(16'hB002, 16'h0030);
        tick();
        head("fill3", 1'b1, 16'hA123, 16'h0011, 3'd3);
        offer(16'hB003, 16'h0040);
        tick();
        head("fill4", 1'b1, 16'hA123, 16'h0011, 3'd4);
        check("full.if_ready", 32'(if_ready), 32'd0);

        // Offer while full is ignored
        offer(16'hC000, 16'h0050);
        tick();
        head("full_ign", 1'b1, 16'hA123, 16'h0011, 3'd4);
        check("full_ign.if_ready", 32'(if_ready), 32'd0);

        // Stall drops with word still offered: pop only, then push+pop
        stall_IM_ID = 1'b0;
        tick();
        head("unstall1", 1'b1, 16'hB001, 16'h0021, 3'd3);
        check("unstall1.if_ready", 32'(if_ready), 32'd1);
        tick();
        head("unstall2", 1'b1, 16'hB002, 16'h0031, 3'd3);

        // Flush with 3 entries, concurrent offer and stall
        stall_IM_ID = 1'b1;
        flow_change_ID_EX = 1'b1;
        offer(16'hD000, 16'h0060);
        tick();
        flow_change_ID_EX = 1'b0;
        if_valid = 1'b0;
        stall_IM_ID = 1'b0;
        head("flush", 1'b0, c_NOP, 16'h0000, 3'd0);
        tick();
        head("flush_drop", 1'b0, c_NOP, 16'h0000, 3'd0);

        // PC wrap at 16'hFFFF
        offer(16'hE000, 16'hFFFF);
        tick();
        head("pcwrap", 1'b1, 16'hE000, 16'h0000, 3'd1);

        // Nine continuous push/pop cycles; pointers wrap past DEPTH
        for (int k = 1; k <= 9; k++) begin
            offer(16'hE000 + 16'(k), 16'h0100 + 16'(k));
            tick();
            head($sformatf("stream%0d", k), 1'b1, 16'hE000 + 16'(k),
                 16'h0101 + 16'(k), 3'd1);
        end
        if_valid = 1'b0;
        tick();
        head("drain", 1'b0, c_NOP, 16'h0000, 3'd0);

        // Reset mid-stream beats flush and push
        stall_IM_ID = 1'b1;
        offer(16'h5001, 16'h0200);
        tick();
        offer(16'h5002, 16'h0201);
        tick();
        head("prerst", 1'b1, 16'h5001, 16'h0201, 3'd2);
        rst = 1'b1;
        flow_change_ID_EX = 1'b1;
        offer(16'h5003, 16'h0202);
        tick();
        rst = 1'b0;
        flow_change_ID_EX = 1'b0;
        if_valid = 1'b0;
        stall_IM_ID = 1'b0;
        head("midrst", 1'b0, c_NOP, 16'h0000, 3'd0);
        check("midrst.if_ready", 32'(if_ready), 32'd1);

        // Queue operates normally after reset
        offer(16'h1234, 16'h0000);
        tick();
        if_valid = 1'b0;
        head("postrst", 1'b1, 16'h1234, 16'h0001, 3'd1);
        tick();
        head("postrst_pop", 1'b0, c_NOP, 16'h0000, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
